keypad_emulator: RTL and testbench

Synthesizable model of the 4x4 matrix keypad as seen from the row-scanning side. It receives one key-press request at a time, then drives the active-low column lines in response to the active-high one-hot row drive. Each press plays out as press bounce, stable hold, release bounce. It sits opposite the keypad scanner, in the FPGA self-test build and in scanner/debouncer benches, in place of the physical keypad.

---
 rtl/keypad_emulator.sv | 171 +++++++++++++++++
 tb/tb_keypad_emulator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// keypad_emulator: behavioural stand-in for a 4x4 matrix keypad, seen from the
// row-scanning side. It plays back one key press per request as press bounce,
// stable hold and release bounce. It drives active-low columns combinationally
// from the active-high row drive.
//
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready.
// req_ready is high only while the FSM is IDLE, and it depends on state alone,
// never on req_valid. Request fields are sampled only on the transfer edge.
// A request presented while busy is neither accepted nor queued. The requester
// keeps req_valid high until req_ready.
module keypad_emulator #(
  parameter int          BOUNCE_W  = 8,
  parameter int          HOLD_W    = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          rows,
  output logic [3:0]          columns,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_key,
  input  logic [BOUNCE_W-1:0] req_bounce,
  input  logic [HOLD_W-1:0]   req_hold,
  output logic                contact,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  // The counter is shared by all phases, so it is sized for the longest field.
  localparam int CNT_W = (HOLD_W > BOUNCE_W) ? HOLD_W : BOUNCE_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PBOUNCE = 2'd1,
    S_HOLD    = 2'd2,
    S_RBOUNCE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [3:0]          key_q, key_d;
  logic [BOUNCE_W-1:0] bounce_q, bounce_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                done_q, done_d;
  logic                contact_w;
  logic [1:0]          row_idx;
  logic [1:0]          col_idx;

  // A hold of zero still closes the switch for one cycle.
  function automatic logic [CNT_W-1:0] hold_len(input logic [HOLD_W-1:0] h);
    if (h == '0) return CNT_ONE;
    return CNT_W'(h);
  endfunction

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // State, counter, LFSR, latched request and done pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lfsr_q   <= SEED;
      key_q    <= '0;
      bounce_q <= '0;
      hold_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      key_q    <= key_d;
      bounce_q <= bounce_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic, contact level and LFSR stepping during the bounce phases.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    key_d     = key_q;
    bounce_d  = bounce_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    contact_w = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          key_d    = req_key;
          bounce_d = req_bounce;
          hold_d   = req_hold;
          if (req_bounce != '0) begin
            state_d = S_PBOUNCE;
            cnt_d   = CNT_W'(req_bounce);
          end else begin
            state_d = S_HOLD;
            cnt_d   = hold_len(req_hold);
          end
        end
      end
      S_PBOUNCE: begin
        contact_w = lfsr_q[0];
        lfsr_d    = lfsr_next(lfsr_q);
        if (cnt_q <= CNT_ONE) begin
          state_d = S_HOLD;
          cnt_d   = hold_len(hold_q);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        contact_w = 1'b1;
        if (cnt_q <= CNT_ONE) begin
          if (bounce_q != '0) begin
            state_d = S_RBOUNCE;
            cnt_d   = CNT_W'(bounce_q);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RBOUNCE: begin
        contact_w = lfsr_q[0];
        lfsr_d    = lfsr_next(lfsr_q);
        if (cnt_q <= CNT_ONE) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign row_idx = key_q[3:2];
  assign col_idx = key_q[1:0];

  // Column sense: only the latched row bit is examined, so there is no clock path.
  always_comb begin
    columns = 4'b1111;
    if (contact_w && rows[2'd3 - row_idx]) begin
      columns[2'd3 - col_idx] = 1'b0;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign contact   = contact_w;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed scenarios followed by randomized requests. An
// expected-timeline model is built per accepted request and is checked every
// cycle against contact, busy, done, req_ready and columns.
module tb_keypad_emulator;

  localparam logic [7:0] SEED = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  columns;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_key;
  logic [7:0]  req_bounce;
  logic [15:0] req_hold;
  logic        contact;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int rows_mode = 2;   // 0 random, 1 walking one-hot, 2 held by driver

  // Per-cycle expectation {busy, contact, done}; an empty queue means idle.
  logic [2:0]  exp_q[$];
  logic [7:0]  m_lfsr;
  logic [3:0]  m_key;

  keypad_emulator #(.BOUNCE_W(8), .HOLD_W(16), .LFSR_SEED(SEED)) dut (
    .clk        (clk),
    .reset      (reset),
    .rows       (rows),
    .columns    (columns),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_key    (req_key),
    .req_bounce (req_bounce),
    .req_hold   (req_hold),
    .contact    (contact),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lstep(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Queue the whole visible timeline of one press: bounce, hold, bounce, done.
  task automatic model_accept(input logic [3:0] k, input int b, input int h);
    int hl;
    hl = (h == 0) ? 1 : h;
    m_key = k;
    for (int i = 0; i < b; i++) begin
      exp_q.push_back({1'b1, m_lfsr[0], 1'b0});
      m_lfsr = lstep(m_lfsr);
    end
    for (int i = 0; i < hl; i++) exp_q.push_back(3'b110);
    for (int i = 0; i < b; i++) begin
      exp_q.push_back({1'b1, m_lfsr[0], 1'b0});
      m_lfsr = lstep(m_lfsr);
    end
    exp_q.push_back(3'b001);
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [2:0] cur;
    logic [3:0] exp_col;
    if (!reset) begin
      exp_q.delete();
      m_lfsr = SEED;
      m_key  = 4'h0;
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_contact", {7'd0, contact}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_ready", {7'd0, req_ready}, 8'd1);
      chk("rst_columns", {4'd0, columns}, 8'h0F);
    end else begin
      cur = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
      exp_col = 4'b1111;
      if (cur[1] && rows[3 - m_key[3:2]]) exp_col[3 - m_key[1:0]] = 1'b0;
      chk("busy", {7'd0, busy}, {7'd0, cur[2]});
      chk("contact", {7'd0, contact}, {7'd0, cur[1]});
      chk("done", {7'd0, done}, {7'd0, cur[0]});
      chk("ready", {7'd0, req_ready}, {7'd0, ~cur[2]});
      chk("columns", {4'd0, columns}, {4'd0, exp_col});
      if (req_valid && !cur[2]) model_accept(req_key, int'(req_bounce), int'(req_hold));
    end
  end

  // ---------------- row drive ----------------
  always @(posedge clk) begin
    #1;
    if (rows_mode == 0) begin
      rows = 4'($urandom_range(0, 15));
    end else if (rows_mode == 1) begin
      if (rows == 4'b0001 || !(rows inside {4'b1000, 4'b0100, 4'b0010})) rows = 4'b1000;
      else rows = rows >> 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the request until the edge it transfers on; returns in the first
  // cycle after acceptance and reports whether done was high in the accept cycle.
  task automatic send(input logic [3:0] k, input int b, input int h, output logic done_seen);
    logic rdy;
    logic dn;
    int   n;
    n = 0;
    dn = 1'b0;
    req_valid  = 1'b1;
    req_key    = k;
    req_bounce = 8'(b);
    req_hold   = 16'(h);
    forever begin
      rdy = req_ready;
      dn  = done;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 600) begin
        chk("send_timeout", 8'd0, 8'd1);
        break;
      end
    end
    req_valid = 1'b0;
    done_seen = dn;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy || exp_q.size() > 0) begin
      tick(1);
      n++;
      if (n > 2000) begin
        chk("idle_timeout", 8'd0, 8'd1);
        break;
      end
    end
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic ds;
    reset      = 1'b0;
    rows       = 4'b1000;
    req_valid  = 1'b0;
    req_key    = 4'h0;
    req_bounce = 8'd0;
    req_hold   = 16'd0;
    tick(3);
    reset = 1'b1;

    // Idle after reset with a row driven.
    tick(2);
    #1;
    chk("t1_columns", {4'd0, columns}, 8'h0F);
    chk("t1_ready", {7'd0, req_ready}, 8'd1);
    chk("t1_busy", {7'd0, busy}, 8'd0);
    chk("t1_done", {7'd0, done}, 8'd0);

    // Key 0, no bounce, hold 5.
    send(4'h0, 0, 5, ds);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_columns", {4'd0, columns}, 8'h07);
      chk("t2_busy", {7'd0, busy}, 8'd1);
      @(posedge clk);
      #1;
    end
    #1;
    chk("t2_done", {7'd0, done}, 8'd1);
    chk("t2_idle_columns", {4'd0, columns}, 8'h0F);
    tick(2);

    // Key 6 (row 1, column 2) with a walking row drive.
    rows_mode = 1;
    send(4'h6, 0, 20, ds);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t3_columns", {4'd0, columns}, (rows == 4'b0100) ? 8'h0D : 8'h0F);
      @(posedge clk);
      #1;
    end
    rows_mode = 2;
    rows = 4'b0001;
    tick(3);

    // Key F, bounce 8, hold 10, first bounce contacts from seed A5 are 1,0,1,0.
    send(4'hF, 8, 10, ds);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_bounce", {7'd0, contact}, (i % 2 == 0) ? 8'd1 : 8'd0);
      @(posedge clk);
      #1;
    end
    tick(6);
    #1;
    chk("t4_hold_columns", {4'd0, columns}, 8'h0E);
    // Single-cycle request while busy must be dropped.
    req_valid = 1'b1;
    req_key   = 4'h3;
    tick(1);
    req_valid = 1'b0;
    tick(1);
    chk("t4_key_kept", {4'd0, columns}, 8'h0E);
    // Held request is taken in the done cycle.
    send(4'h9, 2, 3, ds);
    chk("t5_accept_in_done", {7'd0, ds}, 8'd1);
    chk("t5_busy_next", {7'd0, busy}, 8'd1);
    wait_idle();

    // Reset in the middle of HOLD.
    rows = 4'b1000;
    send(4'h0, 0, 30, ds);
    tick(5);
    #1;
    chk("t6_pre_columns", {4'd0, columns}, 8'h07);
    reset = 1'b0;
    #1;
    chk("t6_rst_columns", {4'd0, columns}, 8'h0F);
    chk("t6_rst_contact", {7'd0, contact}, 8'd0);
    chk("t6_rst_done", {7'd0, done}, 8'd0);
    tick(2);
    reset = 1'b1;
    send(4'hF, 4, 2, ds);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_lfsr_restart", {7'd0, contact}, (i % 2 == 0) ? 8'd1 : 8'd0);
      @(posedge clk);
      #1;
    end
    wait_idle();

    // Randomized requests, back-to-back sends, and one reset mid-press.
    rows_mode = 0;
    for (int it = 0; it < 40; it++) begin
      tick($urandom_range(0, 3));
      send(4'($urandom_range(0, 15)), $urandom_range(0, 6), $urandom_range(0, 8), ds);
      if (it == 20) begin
        tick($urandom_range(1, 4));
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
      end
    end
    wait_idle();
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
